mxv_op_sequencer: RTL and testbench

Sequences the matrix-vector multiply datapath once the command FSM enters its operation phase; its start input is driven by the FSM's OPERATION_EN. For each row, it walks the matrix RAM array and the vector PIPO column by column and multiply-accumulates the products. Each row result is written into the result buffer that the transmit path later drains. It returns op_done to the FSM's OP_DONE input and shares the clear input with the FSM's CLEAR_EN.

---
 rtl/mxv_op_sequencer_pkg.sv | 29 ++
 rtl/mxv_op_sequencer_if.sv | 24 ++
 rtl/mxv_op_sequencer_mac.sv | 24 ++
 rtl/mxv_op_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mxv_op_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mxv_op_sequencer_pkg.sv
// Shared definitions for the matrix-vector multiply operation sequencer.
package mxv_op_sequencer_pkg;

  localparam int unsigned MAX_N  = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned ACC_W  = 2 * DATA_W + IDX_W;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [IDX_W:0]    size_t;
  typedef logic [DATA_W-1:0] elem_t;
  typedef logic [ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE,
    S_ERR
  } seq_state_t;

  // A dimension is usable when it lies in 1..MAX_N.
  function automatic logic size_ok(input size_t n);
    return (n != '0) && (n <= size_t'(MAX_N));
  endfunction

endpackage

// File: rtl/mxv_op_sequencer_if.sv
// Matrix/vector read port and result buffer write port of the sequencer.
interface mxv_op_sequencer_if;
  import mxv_op_sequencer_pkg::*;

  logic  mat_rd_en;
  idx_t  mat_row;
  idx_t  mat_col;
  elem_t mat_rd_data;
  elem_t vec_data;
  logic  res_we;
  idx_t  res_addr;
  acc_t  res_data;

  modport master (
    output mat_rd_en, mat_row, mat_col, res_we, res_addr, res_data,
    input  mat_rd_data, vec_data
  );

  modport slave (
    input  mat_rd_en, mat_row, mat_col, res_we, res_addr, res_data,
    output mat_rd_data, vec_data
  );

endinterface

// File: rtl/mxv_op_sequencer_mac.sv
// Unsigned multiply-accumulate; clr wins over en.
module mxv_mac
  import mxv_op_sequencer_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  en,
  input  elem_t a,
  input  elem_t b,
  output acc_t  acc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(a) * ACC_W'(b);
    end
  end

endmodule

// File: rtl/mxv_op_sequencer.sv
// Walks the matrix row by row, accumulates each dot product and writes it to the result buffer.
module mxv_op_sequencer
  import mxv_op_sequencer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       clear,
  input  size_t                      mat_size,
  mxv_op_sequencer_if.master         bus,
  output logic                       busy,
  output logic                       op_done,
  output logic                       size_err
);

  seq_state_t state_q, state_d;
  size_t      n_q, n_d;
  idx_t       row_q, row_d;
  logic       start_q;
  logic       valid_q;

  logic       rd_en_q, rd_en_d;
  idx_t       mat_row_q, mat_row_d;
  idx_t       mat_col_q, mat_col_d;
  logic       res_we_q, res_we_d;
  idx_t       res_addr_q, res_addr_d;
  logic       busy_q, busy_d;
  logic       op_done_q, op_done_d;
  logic       size_err_q, size_err_d;

  idx_t       last_idx;
  logic       mac_clr;
  acc_t       acc;

  assign last_idx = idx_t'(n_q - size_t'(1));

  // Accumulator restarts at operation launch, after each row commit and on abort.
  assign mac_clr = clear || (state_q == S_LOAD) || (state_q == S_WRITE);

  mxv_mac u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (valid_q),
    .a   (bus.mat_rd_data),
    .b   (bus.vec_data),
    .acc (acc)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    row_d      = row_q;
    rd_en_d    = 1'b0;
    mat_row_d  = '0;
    mat_col_d  = '0;
    res_we_d   = 1'b0;
    res_addr_d = '0;
    op_done_d  = 1'b0;
    size_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !start_q) begin
          n_d     = mat_size;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!size_ok(n_q)) begin
          state_d    = S_ERR;
          op_done_d  = 1'b1;
          size_err_d = 1'b1;
        end else begin
          row_d     = '0;
          state_d   = S_ISSUE;
          rd_en_d   = 1'b1;
          mat_row_d = '0;
          mat_col_d = '0;
        end
      end
      S_ISSUE: begin
        // mat_col_q is the column issued this cycle.
        if (mat_col_q == last_idx) begin
          state_d = S_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          mat_row_d = row_q;
          mat_col_d = mat_col_q + idx_t'(1);
        end
      end
      S_DRAIN: begin
        state_d    = S_WRITE;
        res_we_d   = 1'b1;
        res_addr_d = row_q;
      end
      S_WRITE: begin
        if (row_q == last_idx) begin
          state_d   = S_DONE;
          op_done_d = 1'b1;
        end else begin
          row_d     = row_q + idx_t'(1);
          state_d   = S_ISSUE;
          rd_en_d   = 1'b1;
          mat_row_d = row_q + idx_t'(1);
          mat_col_d = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d    = S_IDLE;
      rd_en_d    = 1'b0;
      mat_row_d  = '0;
      mat_col_d  = '0;
      res_we_d   = 1'b0;
      res_addr_d = '0;
      op_done_d  = 1'b0;
      size_err_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      row_q      <= '0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      mat_row_q  <= '0;
      mat_col_q  <= '0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
      busy_q     <= 1'b0;
      op_done_q  <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      row_q      <= row_d;
      start_q    <= start;
      valid_q    <= clear ? 1'b0 : rd_en_q;
      rd_en_q    <= rd_en_d;
      mat_row_q  <= mat_row_d;
      mat_col_q  <= mat_col_d;
      res_we_q   <= res_we_d;
      res_addr_q <= res_addr_d;
      busy_q     <= busy_d;
      op_done_q  <= op_done_d;
      size_err_q <= size_err_d;
    end
  end

  assign bus.mat_rd_en = rd_en_q;
  assign bus.mat_row   = mat_row_q;
  assign bus.mat_col   = mat_col_q;
  assign bus.res_we    = res_we_q;
  assign bus.res_addr  = res_addr_q;
  assign bus.res_data  = acc;
  assign busy          = busy_q;
  assign op_done       = op_done_q;
  assign size_err      = size_err_q;

endmodule

// File: tb/tb_mxv_op_sequencer.sv
// Scoreboard bench for mxv_op_sequencer with a matrix/vector memory model.
module tb_mxv_op_sequencer;
  import mxv_op_sequencer_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  start;
  logic  clear;
  size_t mat_size;
  logic  busy, op_done, size_err;

  mxv_op_sequencer_if bus_if ();

  mxv_op_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .clear    (clear),
    .mat_size (mat_size),
    .bus      (bus_if.master),
    .busy     (busy),
    .op_done  (op_done),
    .size_err (size_err)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int cyc; int err; } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cnt_rd = 0, cnt_we = 0, cnt_done = 0;
  int s;

  elem_t mem_m [MAX_N][MAX_N];
  elem_t mem_v [MAX_N];

  always @(posedge clk) cyc++;

  // Matrix RAM and vector PIPO: one-cycle read latency, filler when idle.
  always @(posedge clk) begin
    if (bus_if.mat_rd_en) begin
      bus_if.mat_rd_data <= mem_m[bus_if.mat_row][bus_if.mat_col];
      bus_if.vec_data    <= mem_v[bus_if.mat_col];
    end else begin
      bus_if.mat_rd_data <= 8'hA5;
      bus_if.vec_data    <= 8'h5A;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes a result or completes.
  always @(negedge clk) begin
    if (rst) begin
      if (bus_if.mat_rd_en) cnt_rd++;
      if (bus_if.res_we) begin
        cnt_we++;
        if (exp_wr.size() == 0) begin
          check("unexpected_res_we", 1, 0);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("res_addr", int'(bus_if.res_addr), w.addr);
          check("res_data", int'(bus_if.res_data), w.data);
        end
      end
      if (op_done) begin
        cnt_done++;
        if (exp_done.size() == 0) begin
          check("unexpected_op_done", 1, 0);
        end else begin
          done_t d;
          d = exp_done.pop_front();
          check("op_done_cycle", cyc, d.cyc);
          check("size_err", int'(size_err), d.err);
        end
      end else if (size_err) begin
        check("size_err_without_done", 1, 0);
      end
    end
  end

  task automatic push_wr(input int addr, input int data);
    wr_t w;
    w.addr = addr; w.data = data;
    exp_wr.push_back(w);
  endtask

  // Cycle c (1-based, LOAD = 1) is observed at the negedge where cyc == s+c-1.
  task automatic push_done(input int lat, input int err);
    done_t d;
    d.cyc = s + lat - 1; d.err = err;
    exp_done.push_back(d);
  endtask

  task automatic launch(input int n, input bit hold);
    @(negedge clk);
    mat_size = size_t'(n);
    start    = 1'b1;
    s        = cyc + 1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < s + c - 1) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", exp_wr.size() + exp_done.size(), 0);
  endtask

  task automatic load_seq4();
    for (int i = 0; i < 4; i++) begin
      mem_v[i] = elem_t'(i + 1);
      for (int j = 0; j < 4; j++) mem_m[i][j] = elem_t'(i * 4 + j + 1);
    end
  endtask

  initial begin
    int rd0, we0, dn0;
    rst = 1'b0; start = 1'b0; clear = 1'b0; mat_size = '0;
    for (int i = 0; i < MAX_N; i++) begin
      mem_v[i] = '0;
      for (int j = 0; j < MAX_N; j++) mem_m[i][j] = '0;
    end

    // Reset state
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_op_done", int'(op_done), 0);
    check("rst_rd_en", int'(bus_if.mat_rd_en), 0);
    check("rst_res_we", int'(bus_if.res_we), 0);
    check("rst_res_data", int'(bus_if.res_data), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: N=2 small matrix
    mem_m[0][0] = 1; mem_m[0][1] = 2; mem_m[1][0] = 3; mem_m[1][1] = 4;
    mem_v[0] = 5; mem_v[1] = 6;
    push_wr(0, 17); push_wr(1, 39);
    launch(2, 1'b0);
    push_done(10, 0);
    check("t1_busy_c1", int'(busy), 1);
    wait_cycle(10);
    check("t1_busy_c10", int'(busy), 1);
    wait_cycle(11);
    check("t1_busy_c11", int'(busy), 0);
    wait_idle(20);

    // 2: N=8 all 0xFF, worst-case magnitude
    for (int i = 0; i < MAX_N; i++) begin
      mem_v[i] = 8'hFF;
      for (int j = 0; j < MAX_N; j++) mem_m[i][j] = 8'hFF;
    end
    for (int r = 0; r < 8; r++) push_wr(r, 520200);
    launch(8, 1'b0);
    push_done(82, 0);
    wait_idle(120);

    // 3: invalid sizes 0 and 9
    for (int k = 0; k < 2; k++) begin
      rd0 = cnt_rd; we0 = cnt_we;
      launch((k == 0) ? 0 : 9, 1'b0);
      push_done(2, 1);
      wait_cycle(5);
      check("t3_rd_en_count", cnt_rd - rd0, 0);
      check("t3_res_we_count", cnt_we - we0, 0);
      wait_idle(10);
    end

    // 4: clear in row 1 ISSUE, then full rerun
    load_seq4();
    push_wr(0, 30);
    dn0 = cnt_done; we0 = cnt_we;
    launch(4, 1'b0);
    wait_cycle(9);
    check("t4_rd_en_row1", int'(bus_if.mat_rd_en), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t4_busy_after_clear", int'(busy), 0);
    repeat (30) @(negedge clk);
    check("t4_writes_before_clear", cnt_we - we0, 1);
    check("t4_no_done", cnt_done - dn0, 0);
    check("t4_pending", exp_wr.size(), 0);
    push_wr(0, 30); push_wr(1, 70); push_wr(2, 110); push_wr(3, 150);
    launch(4, 1'b0);
    push_done(26, 0);
    wait_idle(50);

    // 5: N=1 with start held high
    mem_m[0][0] = 7; mem_v[0] = 9;
    dn0 = cnt_done; we0 = cnt_we;
    push_wr(0, 63);
    launch(1, 1'b1);
    push_done(5, 0);
    repeat (19) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_done_count", cnt_done - dn0, 1);
    check("t5_we_count", cnt_we - we0, 1);
    wait_idle(5);

    // 6: asynchronous reset during ISSUE
    load_seq4();
    dn0 = cnt_done; we0 = cnt_we;
    launch(4, 1'b0);
    wait_cycle(3);
    check("t6_rd_en_pre", int'(bus_if.mat_rd_en), 1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_rd_en", int'(bus_if.mat_rd_en), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_row", int'(bus_if.mat_row), 0);
    check("t6_rst_res_data", int'(bus_if.res_data), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("t6_idle_busy", int'(busy), 0);
    check("t6_no_writes", cnt_we - we0, 0);
    check("t6_no_done", cnt_done - dn0, 0);

    check("final_pending", exp_wr.size() + exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
